// File: rtl/alu_control_pkg.sv
// Shared encodings and types for the ALU control / multiply-divide block.
package alu_control_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ILL   = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [3:0] ALUCTRL_AND  = 4'b0000;
   localparam logic [3:0] ALUCTRL_OR   = 4'b0001;
   localparam logic [3:0] ALUCTRL_ADD  = 4'b0010;
   localparam logic [3:0] ALUCTRL_SUB  = 4'b0110;
   localparam logic [3:0] ALUCTRL_SLT  = 4'b0111;
   localparam logic [3:0] ALUCTRL_NOR  = 4'b1100;
   localparam logic [3:0] ALUCTRL_HILO = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv
   } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per cycle.
// Divider present only when ALU_CONTROL_MDU_DIV_EN is defined.
module mdu_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            run,
   input  logic            abort,
   input  logic            is_div,
   input  logic            is_signed,
   input  logic [XLEN-1:0] rs,
   input  logic [XLEN-1:0] rt,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] work_q, work_init, step, mul_step, prod;
   logic [XLEN-1:0]   opnd_q, opnd_init, mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic              neg_q;

   // Iterate on magnitudes; the sign is restored from neg_q on the last step
   assign mag_a = (is_signed & rs[XLEN-1]) ? -rs : rs;
   assign mag_b = (is_signed & rt[XLEN-1]) ? -rt : rt;

   assign done = run & (cnt_q == CNT_LAST);

   // Multiply: {acc, multiplier} shifts right, multiplicand added into acc
   assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step = {mul_sum, work_q[XLEN-1:1]};

`ifdef ALU_CONTROL_MDU_DIV_EN
   logic            div_q, negr_q, zero_q, ge;
   logic [XLEN:0]   shifted, diff;
   logic [2*XLEN-1:0] div_step;

   // Restoring divide: {remainder, dividend/quotient} shifts left
   assign shifted  = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
   assign diff     = shifted - {1'b0, opnd_q};
   assign ge       = ~diff[XLEN];
   assign div_step = {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), work_q[XLEN-2:0], ge};
   assign step     = div_q ? div_step : mul_step;

   assign work_init = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
   assign opnd_init = is_div ? mag_b : mag_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= 1'b0;
         negr_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (start) begin
         div_q  <= is_div;
         negr_q <= is_signed & rs[XLEN-1];
         zero_q <= is_div & (rt == '0);
      end
   end
`else
   logic unused_div;
   assign unused_div = is_div;
   assign step       = mul_step;
   assign work_init  = {{XLEN{1'b0}}, mag_b};
   assign opnd_init  = mag_a;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         work_q <= '0;
         opnd_q <= '0;
         neg_q  <= 1'b0;
      end else if (start) begin
         cnt_q  <= '0;
         work_q <= work_init;
         opnd_q <= opnd_init;
         neg_q  <= is_signed & (rs[XLEN-1] ^ rt[XLEN-1]);
      end else if (run) begin
         if (abort) begin
            cnt_q <= '0;
         end else begin
            work_q <= step;
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         end
      end
   end

   // Result reflects the final step so it can be captured on the done edge
   always_comb begin
      prod = neg_q ? -step : step;
      hi   = prod[2*XLEN-1:XLEN];
      lo   = prod[XLEN-1:0];
`ifdef ALU_CONTROL_MDU_DIV_EN
      if (div_q) begin
         hi = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
         lo = zero_q ? '1 : (neg_q ? -step[XLEN-1:0] : step[XLEN-1:0]);
      end
`endif
   end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode with iterative MDU, HI/LO registers and hazard stall.
// Define ALU_CONTROL_MDU_DIV_EN to include div/divu support.
module alu_control_mdu
   import alu_control_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              flush,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   input  logic [XLEN-1:0]   rs_val,
   input  logic [XLEN-1:0]   rt_val,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic              mdu_busy,
   output logic              stall,
   output logic [XLEN-1:0]   hi,
   output logic [XLEN-1:0]   lo,
   output logic              illegal
);

   mdu_state_t      state_q, state_d;
   logic [3:0]      ctrl;
   logic            dec_ill, r_valid, f_mul, f_div, f_mfhilo, f_mthi, f_mtlo, is_signed;
   logic            accept, mdu_done, res_we, mt_ok;
   logic [XLEN-1:0] res_hi, res_lo, hi_q, lo_q;

   assign r_valid   = valid_in & (alu_op == ALUOP_RTYPE);
   assign f_mul     = (funct == FUNCT_MULT) | (funct == FUNCT_MULTU);
`ifdef ALU_CONTROL_MDU_DIV_EN
   assign f_div     = (funct == FUNCT_DIV) | (funct == FUNCT_DIVU);
`else
   assign f_div     = 1'b0;
`endif
   assign f_mfhilo  = (funct == FUNCT_MFHI) | (funct == FUNCT_MFLO);
   assign f_mthi    = (funct == FUNCT_MTHI);
   assign f_mtlo    = (funct == FUNCT_MTLO);
   assign is_signed = (funct == FUNCT_MULT) | (funct == FUNCT_DIV);

   assign mdu_busy = (state_q != StIdle);
   assign accept   = r_valid & (f_mul | f_div) & ~mdu_busy & ~flush;
   assign stall    = r_valid & mdu_busy & (f_mul | f_div | f_mfhilo | f_mthi | f_mtlo);
   assign mt_ok    = r_valid & ~mdu_busy & ~flush;

   always_comb begin
      ctrl    = ALUCTRL_AND;
      dec_ill = 1'b0;
      case (alu_op)
         ALUOP_ADD: ctrl = ALUCTRL_ADD;
         ALUOP_SUB: ctrl = ALUCTRL_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD, FUNCT_ADDU:   ctrl = ALUCTRL_ADD;
               FUNCT_SUB, FUNCT_SUBU:   ctrl = ALUCTRL_SUB;
               FUNCT_AND:               ctrl = ALUCTRL_AND;
               FUNCT_OR:                ctrl = ALUCTRL_OR;
               FUNCT_NOR:               ctrl = ALUCTRL_NOR;
               FUNCT_SLT:               ctrl = ALUCTRL_SLT;
               FUNCT_MFHI, FUNCT_MFLO:  ctrl = ALUCTRL_HILO;
               // MDU ops and HI/LO writes are legal but leave the ALU on code 0
               FUNCT_MTHI, FUNCT_MTLO,
               FUNCT_MULT, FUNCT_MULTU: ctrl = ALUCTRL_AND;
`ifdef ALU_CONTROL_MDU_DIV_EN
               FUNCT_DIV, FUNCT_DIVU:   ctrl = ALUCTRL_AND;
`endif
               default:                 dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
   end

   assign alu_ctrl = CTRL_W'(ctrl);
   assign illegal  = valid_in & dec_ill;

   always_comb begin
      state_d = state_q;
      res_we  = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) state_d = f_div ? StDiv : StMul;
         end
         StMul, StDiv: begin
            if (flush) begin
               state_d = StIdle;
            end else if (mdu_done) begin
               state_d = StIdle;
               res_we  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (res_we) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (mt_ok) begin
         if (f_mthi) hi_q <= rs_val;
         if (f_mtlo) lo_q <= rs_val;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

   mdu_iter #(
      .XLEN(XLEN)
   ) u_mdu_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept),
      .run      (mdu_busy),
      .abort    (flush),
      .is_div   (f_div),
      .is_signed(is_signed),
      .rs       (rs_val),
      .rt       (rt_val),
      .done     (mdu_done),
      .hi       (res_hi),
      .lo       (res_lo)
   );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: decode table, MDU results via scoreboard,
// stall, flush and asynchronous reset behaviour.
module tb_alu_control_mdu;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        rst_n, valid_in, flush;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] rs_val, rt_val;
   logic [3:0]  alu_ctrl;
   logic        mdu_busy, stall, illegal;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb_q[$];

   typedef struct {
      logic [1:0] op;
      logic [5:0] fn;
      logic       v;
      logic [3:0] ctrl;
      logic       ill;
   } dec_vec_t;

   alu_control_mdu #(
      .XLEN  (32),
      .CTRL_W(4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_in(valid_in),
      .flush   (flush),
      .alu_op  (alu_op),
      .funct   (funct),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .alu_ctrl(alu_ctrl),
      .mdu_busy(mdu_busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] r;
      int q, m;
      r = '0;
      case (f)
         F_MULT:  r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         F_MULTU: r = {32'b0, a} * {32'b0, b};
         F_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         F_DIV: begin
            if (b == 0) begin
               r = {a, 32'hFFFF_FFFF};
            end else begin
               q = $signed(a) / $signed(b);
               m = $signed(a) % $signed(b);
               r = {m, q};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      valid_in = 1'b1; alu_op = 2'b10; funct = f; rs_val = v;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = 6'b0;
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold_at);
      int cyc, stall_cnt;
      logic [63:0] exp;
      sb_q.push_back(model(f, a, b));
      valid_in = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = 6'b0;
      cyc = 0; stall_cnt = 0;
      while (mdu_busy && cyc < 100) begin
         if (hold_at != 0 && cyc == hold_at) begin
            valid_in = 1'b1; funct = F_MFLO;
         end
         #1;
         if (valid_in && stall === 1'b1) stall_cnt++;
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (cyc !== 32) begin
         bad++; $display("FAIL busy_cycles f=%b: got %0d want 32", f, cyc);
      end
      if (hold_at != 0) begin
         total++;
         if (stall_cnt !== 32 - hold_at) begin
            bad++; $display("FAIL mflo_stall: got %0d cycles want %0d", stall_cnt, 32 - hold_at);
         end
         total++;
         if (stall !== 1'b0) begin
            bad++; $display("FAIL mflo_release: stall got %b want 0", stall);
         end
         valid_in = 1'b0; funct = 6'b0;
      end
      exp = sb_q.pop_front();
      total++;
      if ({hi, lo} !== exp) begin
         bad++; $display("FAIL result f=%b a=%h b=%h: got %h_%h want %h_%h",
                         f, a, b, hi, lo, exp[63:32], exp[31:0]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; alu_op = 2'b00; funct = '0;
      rs_val = '0; rt_val = '0;
      #12;
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
      total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
      total++;
      if (mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", mdu_busy); end
      total++;
      if (alu_ctrl !== 4'b0010) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0010", alu_ctrl);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_decode;
      dec_vec_t tab [16];
      tab = '{'{2'b10, 6'b100111, 1'b1, 4'b1100, 1'b0},
              '{2'b10, 6'b100000, 1'b1, 4'b0010, 1'b0},
              '{2'b10, 6'b100001, 1'b1, 4'b0010, 1'b0},
              '{2'b10, 6'b100010, 1'b1, 4'b0110, 1'b0},
              '{2'b10, 6'b100011, 1'b1, 4'b0110, 1'b0},
              '{2'b10, 6'b100100, 1'b1, 4'b0000, 1'b0},
              '{2'b10, 6'b100101, 1'b1, 4'b0001, 1'b0},
              '{2'b10, 6'b101010, 1'b1, 4'b0111, 1'b0},
              '{2'b10, 6'b010000, 1'b1, 4'b1111, 1'b0},
              '{2'b10, 6'b010010, 1'b1, 4'b1111, 1'b0},
              '{2'b00, 6'b101010, 1'b1, 4'b0010, 1'b0},
              '{2'b01, 6'b000000, 1'b1, 4'b0110, 1'b0},
              '{2'b11, 6'b100000, 1'b1, 4'b0000, 1'b1},
              '{2'b10, 6'b000000, 1'b1, 4'b0000, 1'b1},
              '{2'b10, 6'b111111, 1'b0, 4'b0000, 1'b0},
              '{2'b10, 6'b100110, 1'b1, 4'b0000, 1'b1}};
      foreach (tab[i]) begin
         alu_op = tab[i].op; funct = tab[i].fn; valid_in = tab[i].v;
         #2;
         total++;
         if (alu_ctrl !== tab[i].ctrl || illegal !== tab[i].ill || stall !== 1'b0) begin
            bad++;
            $display("FAIL decode[%0d] op=%b fn=%b: got ctrl=%b ill=%b stall=%b want %b %b 0",
                     i, tab[i].op, tab[i].fn, alu_ctrl, illegal, stall, tab[i].ctrl, tab[i].ill);
         end
      end
      valid_in = 1'b0; alu_op = 2'b00; funct = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_mthilo;
      mt(F_MTHI, 32'h1357_9BDF);
      total++; if (hi !== 32'h1357_9BDF) begin bad++; $display("FAIL mthi: got %h want 13579bdf", hi); end
      mt(F_MTLO, 32'h2468_ACE0);
      total++;
      if (lo !== 32'h2468_ACE0 || hi !== 32'h1357_9BDF) begin
         bad++; $display("FAIL mtlo: got hi=%h lo=%h want 13579bdf 2468ace0", hi, lo);
      end
   endtask

   task automatic test_mult;
      run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 5);
      run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(F_MULT, 32'h0001_2345, 32'hFFFF_FFFF, 0);
   endtask

`ifdef ALU_CONTROL_MDU_DIV_EN
   task automatic test_div;
      run_op(F_DIVU, 32'd100, 32'd7, 3);
      run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(F_DIVU, 32'h0000_1234, 32'd0, 0);
      run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, 0);
      run_op(F_DIV, 32'hFFFF_FFF7, 32'd0, 0);
   endtask
`else
   task automatic test_div;
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      valid_in = 1'b1; alu_op = 2'b10; funct = F_DIV; rs_val = 32'd50; rt_val = 32'd5;
      #1;
      total++;
      if (illegal !== 1'b1 || stall !== 1'b0 || alu_ctrl !== 4'b0000) begin
         bad++; $display("FAIL div_disabled: got ill=%b stall=%b ctrl=%b want 1 0 0000",
                         illegal, stall, alu_ctrl);
      end
      @(posedge clk); #1;
      funct = F_DIVU;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = '0;
      total++;
      if (mdu_busy !== 1'b0 || hi !== h0 || lo !== l0) begin
         bad++; $display("FAIL div_no_effect: got busy=%b hi=%h lo=%h want 0 %h %h",
                         mdu_busy, hi, lo, h0, l0);
      end
   endtask
`endif

   task automatic test_flush;
      mt(F_MTHI, 32'hAAAA_5555);
      mt(F_MTLO, 32'h0F0F_F0F0);
      valid_in = 1'b1; alu_op = 2'b10; funct = F_MULT; rs_val = 32'd9; rt_val = 32'd9;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = '0;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (mdu_busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", mdu_busy); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (mdu_busy !== 1'b0 || hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_F0F0) begin
         bad++; $display("FAIL flush_abort: got busy=%b hi=%h lo=%h want 0 aaaa5555 0f0ff0f0",
                         mdu_busy, hi, lo);
      end
      repeat (40) @(posedge clk);
      #1;
      total++;
      if (hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_F0F0) begin
         bad++; $display("FAIL flush_late_write: got hi=%h lo=%h want aaaa5555 0f0ff0f0", hi, lo);
      end
      valid_in = 1'b1; funct = F_MULTU; flush = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = '0; flush = 1'b0;
      total++;
      if (mdu_busy !== 1'b0) begin
         bad++; $display("FAIL flush_on_accept: busy got %b want 0", mdu_busy);
      end
   endtask

   task automatic test_reset_mid;
      mt(F_MTHI, 32'hDEAD_BEEF);
`ifdef ALU_CONTROL_MDU_DIV_EN
      funct = F_DIVU;
`else
      funct = F_MULTU;
`endif
      valid_in = 1'b1; alu_op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = '0;
      repeat (12) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (hi !== 32'h0 || lo !== 32'h0 || mdu_busy !== 1'b0) begin
         bad++; $display("FAIL async_reset: got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, mdu_busy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(F_MULT, 32'hFFFF_FFFB, 32'd9, 0);
   endtask

   task automatic test_back_to_back;
      run_op(F_MULTU, 32'h0000_FFFF, 32'h0001_0001, 0);
      run_op(F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
      run_op(F_MULT, 32'h0000_0000, 32'hFFFF_FFFF, 0);
`ifdef ALU_CONTROL_MDU_DIV_EN
      run_op(F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 0);
      run_op(F_DIV, 32'h8000_0000, 32'h0000_0003, 0);
`endif
      run_op(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 0);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mthilo();
      test_mult();
      test_div();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
